// File: rtl/rate_controller_pkg.sv
// Shared widths, fixed-point format, throttle ceiling and FSM encoding for the rate loop.
package rate_controller_pkg;

    localparam int unsigned RATE_BIT_WIDTH  = 16;
    localparam int unsigned RATE_FRAC_WIDTH = 4;   // Q12.4
    localparam int unsigned ACC_WIDTH       = RATE_BIT_WIDTH + 1;
    localparam int unsigned PROD_WIDTH      = 2 * RATE_BIT_WIDTH;
    localparam int unsigned NUM_AXES        = 3;   // yaw, pitch, roll

    typedef logic signed [RATE_BIT_WIDTH-1:0] rate_t;

    localparam rate_t THROTTLE_MAX = 16'sh0fc0;
    localparam rate_t RATE_MIN     = 16'sh8000;
    localparam rate_t RATE_MAX     = 16'sh7fff;
    localparam rate_t RATE_ZERO    = 16'sh0000;

    typedef enum logic [3:0] {
        StWaiting  = 4'd0,
        StError    = 4'd1,
        StPterm0   = 4'd2,
        StPterm1   = 4'd3,
        StPterm2   = 4'd4,
        StIterm0   = 4'd5,
        StIterm1   = 4'd6,
        StIterm2   = 4'd7,
        StSum      = 4'd8,
        StComplete = 4'd9
    } state_e;

endpackage

// File: rtl/sat_clamp.sv
// Clamps a signed value of any width (>= 16) into [lo, hi] and returns it as a 16-bit rate.
module sat_clamp
    import rate_controller_pkg::*;
#(
    parameter int unsigned IN_WIDTH = ACC_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0] i_value,
    input  rate_t                      i_lo,
    input  rate_t                      i_hi,
    output rate_t                      o_value
);

    logic signed [IN_WIDTH-1:0] w_lo;
    logic signed [IN_WIDTH-1:0] w_hi;

    // Bounds are sign-extended so the comparison happens at the input's full width.
    assign w_lo = IN_WIDTH'(i_lo);
    assign w_hi = IN_WIDTH'(i_hi);

    // Select the bound when out of range, otherwise pass the low bits through unchanged.
    always_comb begin
        o_value = i_value[RATE_BIT_WIDTH-1:0];
        if (i_value < w_lo) begin
            o_value = i_lo;
        end else if (i_value > w_hi) begin
            o_value = i_hi;
        end
    end

endmodule

// File: rtl/rate_controller.sv
// Three-axis PI rate controller: one shared multiplier, time-multiplexed over a 10-cycle run.
module rate_controller
    import rate_controller_pkg::*;
#(
    parameter rate_t KP           = 16'sh0010,
    parameter rate_t KI           = 16'sh0002,
    parameter rate_t INT_MAX      = 16'sh0640,
    parameter rate_t RATE_OUT_MAX = 16'sh0320,
    parameter rate_t THROTTLE_ARM = 16'sh0080
) (
    input  logic  us_clk,
    input  logic  resetn,
    input  logic  start_signal,
    input  rate_t throttle_rate_target,
    input  rate_t yaw_rate_target,
    input  rate_t pitch_rate_target,
    input  rate_t roll_rate_target,
    input  rate_t yaw_rate_actual,
    input  rate_t pitch_rate_actual,
    input  rate_t roll_rate_actual,
    output rate_t throttle_rate_out,
    output rate_t yaw_rate_out,
    output rate_t pitch_rate_out,
    output rate_t roll_rate_out,
    output logic  active_signal,
    output logic  complete_signal
);

    localparam rate_t INT_MIN      = -INT_MAX;
    localparam rate_t RATE_OUT_MIN = -RATE_OUT_MAX;

    state_e r_state;
    logic   r_active;
    logic   r_complete;

    rate_t  r_throttle;
    rate_t  r_target [NUM_AXES];
    rate_t  r_actual [NUM_AXES];
    rate_t  r_err    [NUM_AXES];
    rate_t  r_p      [NUM_AXES];
    rate_t  r_i      [NUM_AXES];
    rate_t  r_integ  [NUM_AXES];
    rate_t  r_out    [NUM_AXES];
    rate_t  r_throttle_out;

    logic [1:0]                   w_axis;
    logic                         w_is_pterm;
    rate_t                        w_mul_a;
    rate_t                        w_mul_b;
    logic signed [PROD_WIDTH-1:0] w_prod;
    logic signed [PROD_WIDTH-1:0] w_prod_shift;
    rate_t                        w_mul_sat;
    logic signed [ACC_WIDTH-1:0]  w_integ_sum;
    rate_t                        w_integ_new;
    logic                         w_armed;
    rate_t                        w_iterm;
    rate_t                        w_integ_next;
    rate_t                        w_throttle_sat;
    rate_t                        w_err_sat [NUM_AXES];
    rate_t                        w_sum_sat [NUM_AXES];

    assign throttle_rate_out = r_throttle_out;
    assign yaw_rate_out      = r_out[0];
    assign pitch_rate_out    = r_out[1];
    assign roll_rate_out     = r_out[2];
    assign active_signal     = r_active;
    assign complete_signal   = r_complete;

    // Per-axis error saturation and final P+I output clamp.
    for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
        logic signed [ACC_WIDTH-1:0] w_err_full;
        logic signed [ACC_WIDTH-1:0] w_sum_full;

        assign w_err_full = ACC_WIDTH'(r_target[g]) - ACC_WIDTH'(r_actual[g]);
        assign w_sum_full = ACC_WIDTH'(r_p[g]) + ACC_WIDTH'(r_i[g]);

        sat_clamp #(
            .IN_WIDTH (ACC_WIDTH)
        ) u_err_sat (
            .i_value (w_err_full),
            .i_lo    (RATE_MIN),
            .i_hi    (RATE_MAX),
            .o_value (w_err_sat[g])
        );

        sat_clamp #(
            .IN_WIDTH (ACC_WIDTH)
        ) u_sum_sat (
            .i_value (w_sum_full),
            .i_lo    (RATE_OUT_MIN),
            .i_hi    (RATE_OUT_MAX),
            .o_value (w_sum_sat[g])
        );
    end

    // Decode which axis and which gain the shared multiplier serves this cycle.
    always_comb begin
        w_axis     = 2'd0;
        w_is_pterm = 1'b0;
        case (r_state)
            StPterm0: begin w_axis = 2'd0; w_is_pterm = 1'b1; end
            StPterm1: begin w_axis = 2'd1; w_is_pterm = 1'b1; end
            StPterm2: begin w_axis = 2'd2; w_is_pterm = 1'b1; end
            StIterm0: w_axis = 2'd0;
            StIterm1: w_axis = 2'd1;
            StIterm2: w_axis = 2'd2;
            default:  ;
        endcase
    end

    // Integrator update for the selected axis, bounded symmetrically.
    assign w_integ_sum = ACC_WIDTH'(r_integ[w_axis]) + ACC_WIDTH'(r_err[w_axis]);

    sat_clamp #(
        .IN_WIDTH (ACC_WIDTH)
    ) u_integ_sat (
        .i_value (w_integ_sum),
        .i_lo    (INT_MIN),
        .i_hi    (INT_MAX),
        .o_value (w_integ_new)
    );

    // The only multiplier: err*KP in PTERM, integ_new*KI in ITERM.
    assign w_mul_a      = w_is_pterm ? r_err[w_axis] : w_integ_new;
    assign w_mul_b      = w_is_pterm ? KP : KI;
    assign w_prod       = PROD_WIDTH'(w_mul_a) * PROD_WIDTH'(w_mul_b);
    assign w_prod_shift = w_prod >>> RATE_FRAC_WIDTH;

    sat_clamp #(
        .IN_WIDTH (PROD_WIDTH)
    ) u_mul_sat (
        .i_value (w_prod_shift),
        .i_lo    (RATE_MIN),
        .i_hi    (RATE_MAX),
        .o_value (w_mul_sat)
    );

    // Low throttle means the craft is on the ground: bleed off all integral windup.
    assign w_armed      = (r_throttle >= THROTTLE_ARM);
    assign w_iterm      = w_armed ? w_mul_sat : RATE_ZERO;
    assign w_integ_next = w_armed ? w_integ_new : RATE_ZERO;

    sat_clamp #(
        .IN_WIDTH (RATE_BIT_WIDTH)
    ) u_throttle_sat (
        .i_value (r_throttle),
        .i_lo    (RATE_ZERO),
        .i_hi    (THROTTLE_MAX),
        .o_value (w_throttle_sat)
    );

    // Run sequencer with all datapath registers and registered outputs.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= StWaiting;
            r_active       <= 1'b0;
            r_complete     <= 1'b0;
            r_throttle     <= RATE_ZERO;
            r_throttle_out <= RATE_ZERO;
            for (int ax = 0; ax < NUM_AXES; ax++) begin
                r_target[ax] <= RATE_ZERO;
                r_actual[ax] <= RATE_ZERO;
                r_err[ax]    <= RATE_ZERO;
                r_p[ax]      <= RATE_ZERO;
                r_i[ax]      <= RATE_ZERO;
                r_integ[ax]  <= RATE_ZERO;
                r_out[ax]    <= RATE_ZERO;
            end
        end else begin
            r_complete <= 1'b0;
            case (r_state)
                StWaiting: begin
                    if (start_signal) begin
                        r_throttle  <= throttle_rate_target;
                        r_target[0] <= yaw_rate_target;
                        r_target[1] <= pitch_rate_target;
                        r_target[2] <= roll_rate_target;
                        r_actual[0] <= yaw_rate_actual;
                        r_actual[1] <= pitch_rate_actual;
                        r_actual[2] <= roll_rate_actual;
                        r_active    <= 1'b1;
                        r_state     <= StError;
                    end
                end
                StError: begin
                    for (int ax = 0; ax < NUM_AXES; ax++) begin
                        r_err[ax] <= w_err_sat[ax];
                    end
                    r_state <= StPterm0;
                end
                StPterm0, StPterm1, StPterm2: begin
                    r_p[w_axis] <= w_mul_sat;
                    r_state     <= (r_state == StPterm0) ? StPterm1 :
                                   (r_state == StPterm1) ? StPterm2 : StIterm0;
                end
                StIterm0, StIterm1, StIterm2: begin
                    r_integ[w_axis] <= w_integ_next;
                    r_i[w_axis]     <= w_iterm;
                    r_state         <= (r_state == StIterm0) ? StIterm1 :
                                       (r_state == StIterm1) ? StIterm2 : StSum;
                end
                StSum: begin
                    for (int ax = 0; ax < NUM_AXES; ax++) begin
                        r_out[ax] <= w_sum_sat[ax];
                    end
                    r_throttle_out <= w_throttle_sat;
                    r_active       <= 1'b0;
                    r_complete     <= 1'b1;
                    r_state        <= StComplete;
                end
                StComplete: begin
                    r_state <= StWaiting;
                end
                default: begin
                    // Unreachable encodings: drop back to idle, outputs untouched.
                    r_active <= 1'b0;
                    r_state  <= StWaiting;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rate_controller.sv
// Randomised scoreboard bench for rate_controller with a plain-arithmetic PI reference model.
module tb_rate_controller;

    typedef logic signed [15:0] rate_t;
    typedef struct packed {
        rate_t yaw;
        rate_t pitch;
        rate_t roll;
        rate_t thr;
    } exp_t;

    localparam int KP_I      = 16;
    localparam int KI_I      = 2;
    localparam int INT_LIM   = 1600;
    localparam int OUT_LIM   = 800;
    localparam int ARM_I     = 128;
    localparam int THR_LIM   = 4032;

    logic  us_clk = 1'b0;
    logic  resetn = 1'b0;
    logic  start_signal = 1'b0;
    rate_t throttle_rate_target = '0;
    rate_t yaw_rate_target = '0;
    rate_t pitch_rate_target = '0;
    rate_t roll_rate_target = '0;
    rate_t yaw_rate_actual = '0;
    rate_t pitch_rate_actual = '0;
    rate_t roll_rate_actual = '0;
    rate_t throttle_rate_out;
    rate_t yaw_rate_out;
    rate_t pitch_rate_out;
    rate_t roll_rate_out;
    logic  active_signal;
    logic  complete_signal;

    rate_controller #(
        .KP           (16'sh0010),
        .KI           (16'sh0002),
        .INT_MAX      (16'sh0640),
        .RATE_OUT_MAX (16'sh0320),
        .THROTTLE_ARM (16'sh0080)
    ) dut (
        .us_clk               (us_clk),
        .resetn               (resetn),
        .start_signal         (start_signal),
        .throttle_rate_target (throttle_rate_target),
        .yaw_rate_target      (yaw_rate_target),
        .pitch_rate_target    (pitch_rate_target),
        .roll_rate_target     (roll_rate_target),
        .yaw_rate_actual      (yaw_rate_actual),
        .pitch_rate_actual    (pitch_rate_actual),
        .roll_rate_actual     (roll_rate_actual),
        .throttle_rate_out    (throttle_rate_out),
        .yaw_rate_out         (yaw_rate_out),
        .pitch_rate_out       (pitch_rate_out),
        .roll_rate_out        (roll_rate_out),
        .active_signal        (active_signal),
        .complete_signal      (complete_signal)
    );

    always #5 us_clk = ~us_clk;

    int cyc = 0;
    always @(posedge us_clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   comp_cyc[$];
    int   m_integ[3];
    exp_t prev;
    exp_t mon_e;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference: one complete control step from the requirement formulas.
    task automatic model_run(input rate_t thr, input rate_t yt, input rate_t pt, input rate_t rt,
                             input rate_t ya, input rate_t pa, input rate_t ra, output exp_t e);
        int t[3];
        int a[3];
        int o[3];
        int err;
        int p;
        int i;
        t[0] = int'(yt); t[1] = int'(pt); t[2] = int'(rt);
        a[0] = int'(ya); a[1] = int'(pa); a[2] = int'(ra);
        for (int ax = 0; ax < 3; ax++) begin
            err = sat(t[ax] - a[ax], -32768, 32767);
            p   = sat((err * KP_I) >>> 4, -32768, 32767);
            if (int'(thr) < ARM_I) begin
                m_integ[ax] = 0;
                i = 0;
            end else begin
                m_integ[ax] = sat(m_integ[ax] + err, -INT_LIM, INT_LIM);
                i = sat((m_integ[ax] * KI_I) >>> 4, -32768, 32767);
            end
            o[ax] = sat(p + i, -OUT_LIM, OUT_LIM);
        end
        e.yaw   = 16'(o[0]);
        e.pitch = 16'(o[1]);
        e.roll  = 16'(o[2]);
        e.thr   = 16'(sat(int'(thr), 0, THR_LIM));
    endtask

    // Monitor: every complete pulse consumes one scoreboard entry.
    always @(negedge us_clk) begin
        if (resetn && complete_signal) begin
            comp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_complete: got a complete pulse, expected none (t=%0t)",
                         $time);
            end else begin
                mon_e = exp_q.pop_front();
                check16("yaw_out", yaw_rate_out, mon_e.yaw);
                check16("pitch_out", pitch_rate_out, mon_e.pitch);
                check16("roll_out", roll_rate_out, mon_e.roll);
                check16("throttle_out", throttle_rate_out, mon_e.thr);
            end
        end
    end

    task automatic drive(input rate_t thr, input rate_t yt, input rate_t pt, input rate_t rt,
                         input rate_t ya, input rate_t pa, input rate_t ra);
        throttle_rate_target = thr;
        yaw_rate_target      = yt;
        pitch_rate_target    = pt;
        roll_rate_target     = rt;
        yaw_rate_actual      = ya;
        pitch_rate_actual    = pa;
        roll_rate_actual     = ra;
    endtask

    // One run with per-cycle handshake/hold checks; optional start pulse mid-run.
    task automatic do_run(input rate_t thr, input rate_t yt, input rate_t pt, input rate_t rt,
                          input rate_t ya, input rate_t pa, input rate_t ra, input int pulse_k);
        exp_t e;
        @(negedge us_clk);
        drive(thr, yt, pt, rt, ya, pa, ra);
        start_signal = 1'b1;
        model_run(thr, yt, pt, rt, ya, pa, ra, e);
        exp_q.push_back(e);
        @(posedge us_clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge us_clk);
            if (k == 0) start_signal = 1'b0;
            check1("active", active_signal, k <= 7);
            check1("complete", complete_signal, k == 8);
            if (k < 8) begin
                check16("hold_yaw", yaw_rate_out, prev.yaw);
                check16("hold_throttle", throttle_rate_out, prev.thr);
            end
            if (pulse_k > 0 && k == pulse_k) start_signal = 1'b1;
            else if (pulse_k > 0 && k == pulse_k + 1) start_signal = 1'b0;
        end
        prev = e;
    endtask

    task automatic clear_model();
        for (int ax = 0; ax < 3; ax++) m_integ[ax] = 0;
        prev = '0;
    endtask

    task automatic pulse_reset();
        @(negedge us_clk);
        resetn = 1'b0;
        clear_model();
        @(negedge us_clk);
        check16("rst_yaw", yaw_rate_out, 16'h0000);
        check1("rst_active", active_signal, 1'b0);
        resetn = 1'b1;
    endtask

    task automatic abort_run();
        exp_t e;
        @(negedge us_clk);
        drive(16'sh0200, 16'sh0100, 16'sh0050, -16'sh0050, 16'sh0000, 16'sh0000, 16'sh0000);
        start_signal = 1'b1;
        model_run(16'sh0200, 16'sh0100, 16'sh0050, -16'sh0050, 0, 0, 0, e);
        exp_q.push_back(e);
        @(posedge us_clk);
        @(negedge us_clk);
        start_signal = 1'b0;
        repeat (3) @(negedge us_clk);
        #2;
        resetn = 1'b0;
        void'(exp_q.pop_back());
        clear_model();
        #1;
        check16("abort_yaw", yaw_rate_out, 16'h0000);
        check16("abort_pitch", pitch_rate_out, 16'h0000);
        check16("abort_roll", roll_rate_out, 16'h0000);
        check16("abort_throttle", throttle_rate_out, 16'h0000);
        check1("abort_active", active_signal, 1'b0);
        check1("abort_complete", complete_signal, 1'b0);
        @(negedge us_clk);
        @(negedge us_clk);
        resetn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge us_clk);
            if (k % 4 == 0) check1("abort_idle_active", active_signal, 1'b0);
        end
    endtask

    task automatic held_test();
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            model_run(16'sh0300, 16'sh0040, -16'sh0020, 16'sh0010, 0, 0, 0, e);
            exp_q.push_back(e);
        end
        comp_cyc.delete();
        @(negedge us_clk);
        drive(16'sh0300, 16'sh0040, -16'sh0020, 16'sh0010, 0, 0, 0);
        start_signal = 1'b1;
        repeat (32) @(posedge us_clk);
        @(negedge us_clk);
        start_signal = 1'b0;
        repeat (12) @(negedge us_clk);
        check16("held_runs", 16'(comp_cyc.size()), 16'd4);
        for (int i = 1; i < comp_cyc.size(); i++) begin
            check16("held_period", 16'(comp_cyc[i] - comp_cyc[i-1]), 16'd10);
        end
        prev = e;
    endtask

    function automatic rate_t rand_rate();
        if ($urandom_range(0, 1) == 0) return 16'(int'($urandom_range(0, 1024)) - 512);
        return 16'($urandom());
    endfunction

    function automatic rate_t rand_throttle();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 127));
            1:       return 16'($urandom_range(32768, 65535));
            2:       return 16'($urandom_range(256, 4500));
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        int pk;
        clear_model();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge us_clk);
        check16("reset_yaw", yaw_rate_out, 16'h0000);
        check16("reset_pitch", pitch_rate_out, 16'h0000);
        check16("reset_roll", roll_rate_out, 16'h0000);
        check16("reset_throttle", throttle_rate_out, 16'h0000);
        check1("reset_active", active_signal, 1'b0);
        check1("reset_complete", complete_signal, 1'b0);
        resetn = 1'b1;

        // Basic P+I step on yaw.
        do_run(16'sh0200, 16'sh0100, 0, 0, 0, 0, 0, -1);
        check16("basic_yaw", yaw_rate_out, 16'h0120);
        check16("basic_throttle", throttle_rate_out, 16'h0200);

        // Abort mid-run, then the next run must look like a first run.
        abort_run();
        do_run(16'sh0200, 16'sh0100, 0, 0, 0, 0, 0, -1);
        check16("after_abort_yaw", yaw_rate_out, 16'h0120);

        // Output clamp, both signs.
        pulse_reset();
        do_run(16'sh0200, 0, 0, 16'sh0190, 0, 0, -16'sh0190, -1);
        check16("clamp_pos_roll", roll_rate_out, 16'h0320);
        pulse_reset();
        do_run(16'sh0200, 0, 0, -16'sh0190, 0, 0, 16'sh0190, -1);
        check16("clamp_neg_roll", roll_rate_out, 16'hFCE0);

        // Integrator windup limit.
        pulse_reset();
        for (int r = 0; r < 7; r++) do_run(16'sh0200, 16'sh0100, 0, 0, 0, 0, 0, -1);
        check16("windup_yaw", yaw_rate_out, 16'h01C8);

        // Disarm clears integrators; throttle clamp both ends.
        do_run(16'sh0040, 16'sh0100, 0, 0, 0, 0, 0, -1);
        check16("disarm_yaw", yaw_rate_out, 16'h0100);
        check16("disarm_throttle", throttle_rate_out, 16'h0040);
        do_run(-16'sh1000, 16'sh0100, 0, 0, 0, 0, 0, -1);
        check16("thr_neg", throttle_rate_out, 16'h0000);
        do_run(16'sh1000, 16'sh0100, 0, 0, 0, 0, 0, -1);
        check16("thr_high", throttle_rate_out, 16'h0fc0);

        // Start pulsed while busy must not spawn a second run.
        comp_cyc.delete();
        do_run(16'sh0400, 16'sh0030, 16'sh0020, 16'sh0010, 0, 0, 0, 2);
        repeat (12) @(negedge us_clk);
        check16("busy_start_runs", 16'(comp_cyc.size()), 16'd1);

        held_test();

        // Randomised runs against the model.
        for (int r = 0; r < 25; r++) begin
            pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
            do_run(rand_throttle(), rand_rate(), rand_rate(), rand_rate(),
                   rand_rate(), rand_rate(), rand_rate(), pk);
        end

        repeat (4) @(negedge us_clk);
        check16("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rate_controller.md
RATE_CONTROLLER -- requirements
Module: rate_controller

Interface
REQ-001 SHALL have parameter KP, default 16'h0010 (Q12.4, 1.0): proportional gain.
REQ-002 SHALL have parameter KI, default 16'h0002 (Q12.4, 0.125): integral gain.
REQ-003 SHALL have parameter INT_MAX, default 16'h0640 (100): integrator magnitude limit.
REQ-004 SHALL have parameter RATE_OUT_MAX, default 16'h0320 (50): yaw/pitch/roll output magnitude limit.
REQ-005 SHALL have parameter THROTTLE_ARM, default 16'h0080 (8): throttle below this clears integrators.
REQ-006 us_clk  in  1  system clock.
REQ-007 resetn  in  1  asynchronous, active-low reset.
REQ-008 start_signal  in  1  level request, sampled only in WAITING.
REQ-009 throttle_rate_target, yaw_rate_target, pitch_rate_target, roll_rate_target  in  16 signed  targets, Q12.4 deg/s, from angle stage.
REQ-010 yaw_rate_actual, pitch_rate_actual, roll_rate_actual  in  16 signed  IMU body rates, Q12.4.
REQ-011 throttle_rate_out, yaw_rate_out, pitch_rate_out, roll_rate_out  out  16 signed  commanded rates to motor mixer.
REQ-012 active_signal  out  1  high while computing.
REQ-013 complete_signal  out  1  one-cycle pulse; outputs valid.

Function
REQ-014 FSM states SHALL be WAITING, ERROR, PTERM(axis 0..2), ITERM(axis 0..2), SUM, COMPLETE; axis order yaw, pitch, roll.
REQ-015 On the edge where state=WAITING and start_signal=1 (edge 0), all seven inputs SHALL be latched and state SHALL go to ERROR.
REQ-016 ERROR: per axis err = target - actual in 17 bits, saturated to 16-bit signed.
REQ-017 PTERM: one axis per cycle through a single shared 16x16 signed multiplier; p = sat16((err*KP) >>> 4).
REQ-018 ITERM: one axis per cycle, same multiplier; integ = clamp(integ + err, -INT_MAX, +INT_MAX); i = sat16((integ_new*KI) >>> 4).
REQ-019 If latched throttle < THROTTLE_ARM, ITERM SHALL clear each integrator to 0 and i SHALL be 0.
REQ-020 SUM: out = clamp(p + i (17-bit), -RATE_OUT_MAX, +RATE_OUT_MAX); throttle_rate_out = clamp(throttle, 0, 16'h0fc0).
REQ-021 All four outputs SHALL update only on edge 8; held otherwise.
REQ-022 complete_signal SHALL be high exactly for the cycle following edge 8; COMPLETE then returns to WAITING at edge 9.
REQ-023 active_signal SHALL be high for cycles after edges 0 through 7, low otherwise.
REQ-024 start_signal outside WAITING SHALL be ignored; start held high SHALL yield back-to-back runs every 10 cycles.
REQ-025 Integrators SHALL persist between runs.
REQ-026 Illegal state SHALL recover to WAITING with outputs unchanged.

Reset
REQ-027 resetn low SHALL immediately force state WAITING, all outputs 0, active/complete 0, integrators and latched inputs 0.
REQ-028 Reset mid-run SHALL abort the run; no complete pulse for it.

Structure
REQ-029 RATE_BIT_WIDTH, Q12.4 fraction width (4) and THROTTLE_MAX 16'h0fc0 SHALL come from common_defines.v; gains/limits remain parameters.
REQ-030 A sub-module sat_clamp (signed value, lo, hi -> clamped 16-bit) SHALL be reused for all saturation.
REQ-031 Exactly one multiplier SHALL be inferred.

Verification
REQ-032 Reset asserted mid-run -> all outputs 0, active 0, no complete pulse; next start behaves as first run.
REQ-033 throttle 0x0200, yaw target 0x0100, actual 0 -> yaw_rate_out 0x0120 (p 0x0100 + i 0x0020), complete high exactly 8 cycles after edge 0.
REQ-034 roll target 0x0190, actual 0xFE70 -> sum 0x0384 clamped to 0x0320; mirrored inputs -> 0xFCE0.
REQ-035 Seven consecutive runs, yaw err 0x0100, throttle 0x0200 -> integrator caps at 0x0640, yaw_rate_out settles at 0x01C8.
REQ-036 throttle 0x0040 after windup -> integrators 0, yaw_rate_out 0x0100 (P only), throttle_rate_out 0x0040; throttle 0xF000 -> 0x0000, 0x1000 -> 0x0fc0.
REQ-037 start pulsed during PTERM -> ignored, single complete pulse; start held high -> complete every 10 cycles.
